factorial_bcd_converter: RTL
============================

# factorial_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the N-bit factorial unit and consumes its 20*N-bit Factorial result. It uses iterative shift-add-3 (double dabble), one input bit per clock, and produces packed BCD digits plus a significant-digit count for the decimal display/readout stage. Valid/ready handshakes on both sides let the factorial stage and the display stage run decoupled.

## Interface
- N, 4, operand width of the upstream factorial unit
- W, 20*N, binary input width (80 for N=4)
- D, 25, BCD digits produced; must satisfy 10^D > 2^W - 1 (25 for W=80)
- CW, 5, Digit_Count width; must hold D (ceil(log2(D+1)))

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- In_Valid  in  1  Binary holds a value to convert
- In_Ready  out  1  converter can accept a value
- Binary  in  W  unsigned value (Factorial output)
- Out_Valid  out  1  BCD/Digit_Count hold a finished result
- Out_Ready  in  1  downstream accepts result
- BCD  out  4*D  packed BCD; digit 0 (units) in bits [3:0], digit k in [4k+3:4k]
- Digit_Count  out  CW  significant digits in BCD, 1..D (value 0 reports 1)

## Operation
- One clock, synchronous active-high reset; reset is sampled only on rising edges of clk.
- States: IDLE, CONVERT, DONE.
- IDLE: In_Ready=1, Out_Valid=0. On an edge with In_Valid=1, load shift register <= Binary, BCD accumulator <= 0, bit counter <= W, and go to CONVERT. In_Valid=0 means stay.
- CONVERT: In_Ready=0, Out_Valid=0. Each edge:
  - Every accumulator digit >= 5 gets +3.
  - Then {accumulator, shift register} shifts left by 1.
  - Counter decrements.
  - On the edge where the counter goes 1->0, move to DONE.
- DONE: Out_Valid=1, In_Ready=0.
  - BCD equals the accumulator register.
  - Digit_Count = 1 + index of the highest nonzero digit, or 1 if all digits are zero.
  - BCD and Digit_Count are held stable until handshake.
  - On an edge with Out_Ready=1, go to IDLE. Out_Ready=0 means hold indefinitely.
- In_Valid is ignored outside IDLE. Binary is sampled only on the acceptance edge, so upstream may change it afterward.
- Out_Ready is ignored outside DONE.
- Arithmetic is unsigned. Digit adjust is 4-bit modulo; no carry between digits occurs for valid D.
- Reset mid-operation: an in-flight conversion or unconsumed result is discarded. The block is in IDLE with reset values on the next cycle.

## Timing
- Reset values after an edge with rst=1: state IDLE, In_Ready=1, Out_Valid=0, BCD=0, Digit_Count=1, counter=0, shift register=0.
- Accept edge e0 -> W CONVERT edges e1..eW -> Out_Valid is high in the cycle after eW. Latency from accept edge to Out_Valid is W cycles (80 at default).
- Out_Valid and Out_Ready high on edge eX -> IDLE after eX (In_Ready=1). The next accept is possible at eX+1.
- Minimum initiation interval is W+2 cycles with no backpressure.
- Out_Valid and In_Ready are never high in the same cycle.
- In_Valid=1 continuously: exactly one value is accepted per IDLE visit. No value is accepted during CONVERT or DONE.
- rst and handshake on the same edge: rst wins.

## Test plan
- Reset then Binary=0, In_Valid pulse -> Out_Valid after exactly 80 cycles, BCD=0, Digit_Count=1.
- Binary=24 (4!) -> BCD digits [1]=2, [0]=4, all others 0, Digit_Count=2. Binary=3628800 (10!) -> BCD 3628800, Digit_Count=7.
- Binary=1307674368000 (15!), then Binary=2^80-1 back-to-back with In_Valid held high:
  - First result is 1307674368000 with count 13.
  - Second result is 1208925819614629174706175 with count 25.
  - Second accept occurs one cycle after the first output handshake.
- Backpressure: Out_Ready=0 for 10 cycles in DONE while In_Valid=1 with a new Binary:
  - BCD and Digit_Count stay stable.
  - In_Ready stays 0 and the new value is not taken.
  - After Out_Ready=1, the new value is accepted on the next cycle.
- Reset mid-conversion: assert rst 40 cycles after accepting 3628800 -> next cycle IDLE, Out_Valid=0, BCD=0, Digit_Count=1. A fresh conversion of 24 then gives the correct result.
- Sweep: feed n! for n=0..15 (N=4) and compare BCD and Digit_Count against a reference decimal model for every result.

Source files
------------

// File: rtl/factorial_bcd_converter.sv
// factorial_bcd_converter
//   Sequential binary-to-BCD converter (double dabble, one input bit per clock)
//   placed downstream of the factorial unit. Produces packed BCD digits plus a
//   count of significant digits for the display stage.
//
// Ports
//   clk          in   clock, rising-edge
//   rst          in   synchronous active-high reset
//   In_Valid     in   Binary holds a value to convert
//   In_Ready     out  converter accepts a value (IDLE)
//   Binary       in   W-bit unsigned value
//   Out_Valid    out  BCD/Digit_Count hold a finished result (DONE)
//   Out_Ready    in   downstream takes the result
//   BCD          out  4*D packed BCD, digit 0 in [3:0]
//   Digit_Count  out  significant digits, 1..D
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | waiting for In_Valid, In_Ready high
// S_CONVERT| one shift-add-3 step per clock, W steps total
// S_DONE   | result presented, waiting for Out_Ready
module factorial_bcd_converter #(
  parameter int N  = 4,
  parameter int W  = 20 * N,
  parameter int D  = 25,
  parameter int CW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [W-1:0]    Binary,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [4*D-1:0]  BCD,
  output logic [CW-1:0]   Digit_Count
);

  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t             state_q;
  logic [W-1:0]       shift_q;
  logic [W-1:0]       shift_d;
  logic [4*D-1:0]     acc_q;
  logic [4*D-1:0]     acc_adj;
  logic [4*D-1:0]     acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CW-1:0]      dcnt_q;
  logic [CW-1:0]      dcnt_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [3:0]         dig;

  // One double-dabble step: adjust every digit >= 5, then shift the
  // concatenated {accumulator, shift register} left by one bit.
  always_comb begin
    acc_adj = '0;
    dig     = '0;
    for (int k = 0; k < D; k++) begin
      dig = acc_q[4*k +: 4];
      acc_adj[4*k +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    acc_d   = {acc_adj[4*D-2:0], shift_q[W-1]};
    shift_d = {shift_q[W-2:0], 1'b0};
  end

  // Digit count from the final accumulator value; highest nonzero digit wins.
  always_comb begin
    dcnt_d = CW'(1);
    for (int k = 0; k < D; k++) begin
      if (acc_d[4*k +: 4] != 4'd0) dcnt_d = CW'(k + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dcnt_q      <= CW'(1);
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (In_Valid) begin
            shift_q    <= Binary;
            acc_q      <= '0;
            cnt_q      <= CNT_W'(W);
            in_ready_q <= 1'b0;
            state_q    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          acc_q   <= acc_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            dcnt_q      <= dcnt_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (Out_Ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign In_Ready    = in_ready_q;
  assign Out_Valid   = out_valid_q;
  assign BCD         = acc_q;
  assign Digit_Count = dcnt_q;

endmodule
